// File: rtl/imem_dmem_arbiter_pkg.sv
// imem_dmem_arbiter_pkg: shared types, encodings and helpers for the fetch/LSU memory arbiter
package imem_dmem_arbiter_pkg;

    localparam int REG_BUS = 64;
    localparam logic [REG_BUS-1:0] PC_START = 64'h8000_0000;

    typedef logic [REG_BUS-1:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ACCESS,
        ARB_RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_IF,
        OWNER_LSU
    } owner_t;

    typedef struct packed {
        owner_t owner;
        word_t  addr;
        logic   wen;
        word_t  wdata;
        word_t  wmask;
    } req_t;

    // Byte address to 64-bit word index; wraps modulo 2^64 with no range check.
    function automatic word_t word_idx(input word_t addr, input word_t base);
        return (addr - base) >> 3;
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// imem_dmem_arbiter_if: fetch, load/store and memory-port signals of the arbiter
interface imem_dmem_arbiter_if;
    import imem_dmem_arbiter_pkg::*;

    logic  if_req_valid;
    logic  if_req_ready;
    word_t if_req_addr;
    logic  if_flush;
    logic  if_rsp_valid;
    word_t if_rsp_data;
    logic  lsu_req_valid;
    logic  lsu_req_ready;
    word_t lsu_req_addr;
    logic  lsu_req_wen;
    word_t lsu_req_wdata;
    word_t lsu_req_wmask;
    logic  lsu_rsp_valid;
    word_t lsu_rsp_rdata;
    logic  mem_en;
    word_t mem_ridx;
    word_t mem_rdata;
    word_t mem_widx;
    word_t mem_wdata;
    word_t mem_wmask;
    logic  mem_wen;

    modport slave (
        input  if_req_valid, if_req_addr, if_flush,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        output mem_en, mem_ridx, mem_widx, mem_wdata, mem_wmask, mem_wen
    );

    modport master (
        output if_req_valid, if_req_addr, if_flush,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata,
        input  mem_en, mem_ridx, mem_widx, mem_wdata, mem_wmask, mem_wen
    );

endinterface

// File: rtl/imem_dmem_arbiter_prio.sv
// imem_dmem_arbiter_prio: LSU-priority grant select with a streak bound so fetch is never starved
module imem_dmem_arbiter_prio #(
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic clock,
    input  logic rst,
    input  logic if_valid_i,
    input  logic lsu_valid_i,
    input  logic can_accept_i,
    output logic if_grant_o,
    output logic lsu_grant_o
);

    localparam int SW = $clog2(MAX_LSU_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;
    logic          starve;

    // Grant decision and streak update: the streak only grows while fetch is actually waiting.
    always_comb begin
        starve      = if_valid_i && streak_q == SW'(MAX_LSU_STREAK);
        lsu_grant_o = can_accept_i && lsu_valid_i && !starve;
        if_grant_o  = can_accept_i && if_valid_i && !(lsu_valid_i && !starve);
        streak_d    = (!if_valid_i || if_grant_o) ? '0 :
                      (lsu_grant_o && streak_q != SW'(MAX_LSU_STREAK)) ? streak_q + 1'b1 : streak_q;
    end

    // Streak counter register.
    always_ff @(posedge clock) begin
        streak_q <= rst ? '0 : streak_d;
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one 64-bit memory port between instruction fetch and load/store
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter word_t BASE_ADDR      = PC_START,
    parameter int    MAX_LSU_STREAK = 4
) (
    input logic                  clock,
    input logic                  rst,
    imem_dmem_arbiter_if.slave   bus
);

    arb_state_t state_q, state_d;
    req_t       req_q, req_d;
    word_t      rdata_q, rdata_d;
    logic       flush_q, flush_d;
    logic       if_grant, lsu_grant, can_accept, access, resp;
    word_t      idx;

    assign can_accept = state_q != ARB_ACCESS;
    assign access     = state_q == ARB_ACCESS;
    assign resp       = state_q == ARB_RESP;
    assign idx        = word_idx(req_q.addr, BASE_ADDR);

    imem_dmem_arbiter_prio #(
        .MAX_LSU_STREAK (MAX_LSU_STREAK)
    ) u_prio (
        .clock        (clock),
        .rst          (rst),
        .if_valid_i   (bus.if_req_valid),
        .lsu_valid_i  (bus.lsu_req_valid),
        .can_accept_i (can_accept),
        .if_grant_o   (if_grant),
        .lsu_grant_o  (lsu_grant)
    );

    // State register.
    always_ff @(posedge clock) begin
        state_q <= rst ? ARB_IDLE : state_d;
    end

    // Next state: every accept starts an access; a response cycle may accept the next one.
    always_comb begin
        state_d = access ? ARB_RESP : (if_grant || lsu_grant) ? ARB_ACCESS : ARB_IDLE;
    end

    // Request latch, read-data capture and stale-fetch tracking for the transaction in flight.
    always_comb begin
        req_d   = lsu_grant ? req_t'{OWNER_LSU, bus.lsu_req_addr, bus.lsu_req_wen, bus.lsu_req_wdata, bus.lsu_req_wmask} :
                  if_grant  ? req_t'{OWNER_IF, bus.if_req_addr, 1'b0, '0, '0} : req_q;
        rdata_d = access ? bus.mem_rdata : rdata_q;
        flush_d = (if_grant || lsu_grant) ? (if_grant && bus.if_flush) :
                  flush_q || (bus.if_flush && req_q.owner == OWNER_IF && state_q != ARB_IDLE);
    end

    // Datapath registers; reset drops any pending transaction.
    always_ff @(posedge clock) begin
        req_q   <= rst ? req_t'{OWNER_NONE, '0, 1'b0, '0, '0} : req_d;
        rdata_q <= rst ? '0 : rdata_d;
        flush_q <= rst ? 1'b0 : flush_d;
    end

    // Outputs: memory port driven only during ACCESS, response pulsed to the owner in RESP.
    always_comb begin
        bus.if_req_ready  = if_grant;
        bus.lsu_req_ready = lsu_grant;
        bus.mem_en        = access;
        bus.mem_wen       = access && req_q.wen;
        bus.mem_ridx      = access ? idx : '0;
        bus.mem_widx      = access ? idx : '0;
        bus.mem_wdata     = access ? req_q.wdata : '0;
        bus.mem_wmask     = access ? req_q.wmask : '0;
        bus.if_rsp_valid  = resp && req_q.owner == OWNER_IF && !flush_q && !bus.if_flush;
        bus.lsu_rsp_valid = resp && req_q.owner == OWNER_LSU;
        bus.if_rsp_data   = rdata_q;
        bus.lsu_rsp_rdata = rdata_q;
    end

endmodule
